// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the IF/ID decoupling buffer.
// Optional perf counters are enabled with IF_ID_PERF_EN.
package if_id_buffer_pkg;

   localparam int unsigned XLEN     = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] return_pc;
   } entry_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// slave = the buffer, master = the pipeline around it.
interface if_id_buffer_if;
   import if_id_buffer_pkg::*;

   logic            if_valid_i;
   logic [XLEN-1:0] inst_i;
   logic [XLEN-1:0] pc_i;
   logic [XLEN-1:0] return_pc_i;
   logic            if_ready_o;
   logic            data_suspend_i;
   logic            flush_i;
   logic            id_valid_o;
   logic [XLEN-1:0] id_inst_o;
   logic [XLEN-1:0] id_pc_o;
   logic [XLEN-1:0] id_return_pc_o;

   modport slave (
      input  if_valid_i, inst_i, pc_i, return_pc_i,
      input  data_suspend_i, flush_i,
      output if_ready_o, id_valid_o,
      output id_inst_o, id_pc_o, id_return_pc_o
   );

   modport master (
      output if_valid_i, inst_i, pc_i, return_pc_i,
      output data_suspend_i, flush_i,
      input  if_ready_o, id_valid_o,
      input  id_inst_o, id_pc_o, id_return_pc_o
   );

endinterface

// File: rtl/if_id_entry_ram.sv
// DEPTH x entry register file: one write port, one async read port.
// Contents are never reset; validity is tracked by the owner.
module if_id_entry_ram
   import if_id_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  entry_t        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output entry_t        rdata_o
);

   entry_t mem_q [DEPTH];

   // write the fetched entry into its slot
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling queue; empty head presents a NOP bubble.
// Define IF_ID_PERF_EN to add stall/flush event counters.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         reset_i,
`ifdef IF_ID_PERF_EN
   output logic [31:0]  perf_stall_cnt_o,
   output logic [31:0]  perf_flush_cnt_o,
`endif
   if_id_buffer_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          head_vld;
   logic          enq;
   logic          deq;
   entry_t        wdata;
   entry_t        head;

   assign head_vld = (count_q != '0);
   assign bus.if_ready_o = (count_q != CW'(DEPTH));

   assign enq = bus.if_valid_i & bus.if_ready_o & ~bus.flush_i;
   assign deq = head_vld & ~bus.data_suspend_i & ~bus.flush_i;

   assign wdata = '{inst:      bus.inst_i,
                    pc:        bus.pc_i,
                    return_pc: bus.return_pc_i};

   if_id_entry_ram #(.DEPTH(DEPTH)) u_ram (
      .clk_i   (clk_i),
      .we_i    (enq),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   // pointer/count next state; flush empties the queue
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(enq) - CW'(deq);
      end
   end

   // queue control registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign bus.id_valid_o     = head_vld;
   assign bus.id_inst_o      = head_vld ? head.inst      : NOP_INST;
   assign bus.id_pc_o        = head_vld ? head.pc        : '0;
   assign bus.id_return_pc_o = head_vld ? head.return_pc : '0;

`ifdef IF_ID_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // count held-head stall cycles and redirect cycles
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (head_vld & bus.data_suspend_i & ~bus.flush_i)
            stall_q <= stall_q + 32'd1;
         if (bus.flush_i)
            flush_q <= flush_q + 32'd1;
      end
   end

   assign perf_stall_cnt_o = stall_q;
   assign perf_flush_cnt_o = flush_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer against a queue model.
// Build with IF_ID_PERF_EN defined to also exercise the perf counters.
module tb_if_id_buffer;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] rpc;
   } ent_t;

   logic clk = 1'b0;
   logic reset_i;
   int   errors = 0;
   int   checks = 0;

   ent_t        mq[$];
   logic [31:0] m_stall = '0;
   logic [31:0] m_flush = '0;

   if_id_buffer_if bus();

`ifdef IF_ID_PERF_EN
   logic [31:0] perf_stall_cnt_o;
   logic [31:0] perf_flush_cnt_o;
`endif

   if_id_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
`ifdef IF_ID_PERF_EN
      .perf_stall_cnt_o (perf_stall_cnt_o),
      .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("id_valid", 32'(bus.id_valid_o), 32'(mq.size() != 0));
      chk("if_ready", 32'(bus.if_ready_o), 32'(mq.size() != DEPTH));
      chk("id_inst", bus.id_inst_o, mq.size() ? mq[0].inst : NOP);
      chk("id_pc", bus.id_pc_o, mq.size() ? mq[0].pc : 32'h0);
      chk("id_rpc", bus.id_return_pc_o, mq.size() ? mq[0].rpc : 32'h0);
`ifdef IF_ID_PERF_EN
      chk("perf_stall", perf_stall_cnt_o, m_stall);
      chk("perf_flush", perf_flush_cnt_o, m_flush);
`endif
   endtask

   // one clock: drive, advance the model, clock, compare
   task automatic cycle(input logic rst, input logic v,
                        input logic [31:0] inst, input logic [31:0] pc,
                        input logic sus, input logic fl);
      ent_t e;
      bit   en, de;
      reset_i            = rst;
      bus.if_valid_i     = v;
      bus.inst_i         = inst;
      bus.pc_i           = pc;
      bus.return_pc_i    = pc + 32'd4;
      bus.data_suspend_i = sus;
      bus.flush_i        = fl;
      if (rst) begin
         mq.delete();
         m_stall = '0;
         m_flush = '0;
      end else if (fl) begin
         mq.delete();
         m_flush = m_flush + 32'd1;
      end else begin
         if (mq.size() != 0 && sus) m_stall = m_stall + 32'd1;
         en = v && (mq.size() < DEPTH);
         de = (mq.size() != 0) && !sus;
         if (de) void'(mq.pop_front());
         if (en) begin
            e.inst = inst; e.pc = pc; e.rpc = pc + 32'd4;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      reset_i            = 1'b1;
      bus.if_valid_i     = 1'b0;
      bus.inst_i         = '0;
      bus.pc_i           = '0;
      bus.return_pc_i    = '0;
      bus.data_suspend_i = 1'b0;
      bus.flush_i        = 1'b0;

      // reset held two cycles while IF offers words
      cycle(1, 1, 32'hdead_beef, 32'h40, 0, 0);
      cycle(1, 1, 32'hdead_beef, 32'h44, 0, 0);
      chk("rst_valid", 32'(bus.id_valid_o), 32'd0);
      chk("rst_inst", bus.id_inst_o, 32'h13);
      chk("rst_ready", 32'(bus.if_ready_o), 32'd1);

      // streaming
      cycle(0, 1, 32'h1000_0001, 32'h0, 0, 0);
      chk("stream_pc0", bus.id_pc_o, 32'h0);
      chk("stream_rpc0", bus.id_return_pc_o, 32'h4);
      cycle(0, 1, 32'h1000_0002, 32'h4, 0, 0);
      chk("stream_pc1", bus.id_pc_o, 32'h4);
      chk("stream_rpc1", bus.id_return_pc_o, 32'h8);
      cycle(0, 1, 32'h1000_0003, 32'h8, 0, 0);
      chk("stream_pc2", bus.id_pc_o, 32'h8);
      chk("stream_rpc2", bus.id_return_pc_o, 32'hC);
      cycle(0, 0, 32'h0, 32'h0, 0, 0);
      chk("stream_empty", 32'(bus.id_valid_o), 32'd0);

      // fill under stall
      cycle(0, 1, 32'h2000_0001, 32'h20, 1, 0);
      cycle(0, 1, 32'h2000_0002, 32'h24, 1, 0);
      chk("fill_ready", 32'(bus.if_ready_o), 32'd0);
      cycle(0, 1, 32'h2000_0003, 32'h28, 1, 0);
      chk("fill_head", bus.id_pc_o, 32'h20);
      cycle(0, 0, 32'h0, 32'h0, 0, 0);
      chk("drain_pc1", bus.id_pc_o, 32'h24);
      cycle(0, 0, 32'h0, 32'h0, 0, 0);
      chk("drain_ready", 32'(bus.if_ready_o), 32'd1);

      // flush on full buffer drops the concurrent word
      cycle(0, 1, 32'h3000_0001, 32'h30, 1, 0);
      cycle(0, 1, 32'h3000_0002, 32'h34, 1, 0);
      cycle(0, 1, 32'h3000_0003, 32'h100, 0, 1);
      chk("flush_valid", 32'(bus.id_valid_o), 32'd0);
      cycle(0, 0, 32'h0, 32'h0, 0, 0);
      chk("flush_nodeliv", bus.id_pc_o, 32'h0);

      // continuous enq/deq with one entry in flight across wraps
      cycle(0, 1, 32'h4000_0000, 32'h200, 0, 0);
      for (int i = 1; i <= 10; i++)
         cycle(0, 1, 32'h4000_0000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0);
      chk("wrap_pc", bus.id_pc_o, 32'h228);
      cycle(0, 0, 32'h0, 32'h0, 0, 0);

`ifdef IF_ID_PERF_EN
      cycle(1, 0, 32'h0, 32'h0, 0, 0);
      cycle(0, 1, 32'h5000_0000, 32'h300, 1, 0);
      for (int i = 0; i < 5; i++)
         cycle(0, 0, 32'h0, 32'h0, 1, 0);
      cycle(0, 0, 32'h0, 32'h0, 0, 1);
      cycle(0, 0, 32'h0, 32'h0, 0, 1);
      chk("perf_stall5", perf_stall_cnt_o, 32'd5);
      chk("perf_flush2", perf_flush_cnt_o, 32'd2);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(99) == 0),
               1'($urandom_range(1)),
               $urandom(),
               {$urandom_range(32'h3fff_ffff), 2'b00},
               ($urandom_range(2) == 0),
               ($urandom_range(15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
